// File: rtl/compress_sched_pkg.sv
// Shared definitions for the COMPRESS scheduler: FSM state encoding,
// operand/result widths and the law-select encoding.
package compress_sched_pkg;

    localparam int SR_W_DEF = 16;
    localparam int SP_W     = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    typedef enum logic {
        LAW_U = 1'b0,
        LAW_A = 1'b1
    } law_t;

endpackage

// File: rtl/compress_sched_if.sv
// Requester-side bundle of the COMPRESS scheduler.
// master: channel requesters (req, sr_in, law_in out; gnt, done, sp_out, sp_chan in).
// slave : the scheduler itself (the reverse directions).
interface compress_sched_if
    import compress_sched_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int SR_W = SR_W_DEF,
    parameter int CH_W = $clog2(N_CH)
);
    logic [N_CH-1:0]      req;
    logic [N_CH*SR_W-1:0] sr_in;
    logic [N_CH-1:0]      law_in;
    logic [N_CH-1:0]      gnt;
    logic [N_CH-1:0]      done;
    logic [SP_W-1:0]      sp_out;
    logic [CH_W-1:0]      sp_chan;

    modport master (
        output req, sr_in, law_in,
        input  gnt, done, sp_out, sp_chan
    );

    modport slave (
        input  req, sr_in, law_in,
        output gnt, done, sp_out, sp_chan
    );
endinterface

// File: rtl/compress_sched_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr.
// Ports: req (N), ptr (W) in; onehot (N), idx (W), any out.
module compress_sched_rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);
    int          pos;
    logic [W-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = 0;
        cand   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            pos  = (int'(ptr) + j) % N;
            cand = W'(pos);
            if (req[cand]) begin
                onehot       = '0;
                onehot[cand] = 1'b1;
                idx          = cand;
                any          = 1'b1;
            end
        end
    end
endmodule

// File: rtl/compress_sched.sv
// Round-robin scheduler sharing one COMPRESS unit between N_CH channels.
// Ports: clk, reset (async, active high); bus (requester bundle, slave);
// busy out; cmp_sr/cmp_law to COMPRESS; cmp_sp from COMPRESS.
module compress_sched
    import compress_sched_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CMP_LAT = 1,
    parameter int SR_W    = SR_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    compress_sched_if.slave bus,
    output logic            busy,
    output logic [SR_W-1:0] cmp_sr,
    output logic            cmp_law,
    input  logic [SP_W-1:0] cmp_sp
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int CNT_W = $clog2(CMP_LAT + 1);

    state_t           state, state_n;
    logic [CH_W-1:0]  ptr, ptr_n;
    logic [CH_W-1:0]  cur_chan, chan_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [SR_W-1:0]  sr_q, sr_n;
    logic             law_q, law_n;
    logic [N_CH-1:0]  gnt_q, gnt_n;
    logic [N_CH-1:0]  done_q, done_n;
    logic [SP_W-1:0]  sp_q, sp_n;
    logic [CH_W-1:0]  spc_q, spc_n;

    logic [N_CH-1:0]  pick;
    logic [CH_W-1:0]  win;
    logic             any_req;

    compress_sched_rr_pick #(
        .N (N_CH),
        .W (CH_W)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .onehot (pick),
        .idx    (win),
        .any    (any_req)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            ptr      <= '0;
            cur_chan <= '0;
            cnt      <= '0;
            sr_q     <= '0;
            law_q    <= 1'b0;
            gnt_q    <= '0;
            done_q   <= '0;
            sp_q     <= '0;
            spc_q    <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            cur_chan <= chan_n;
            cnt      <= cnt_n;
            sr_q     <= sr_n;
            law_q    <= law_n;
            gnt_q    <= gnt_n;
            done_q   <= done_n;
            sp_q     <= sp_n;
            spc_q    <= spc_n;
        end
    end

    // Operands only change on a grant, so COMPRESS sees them stable
    // for the whole conversion and until the next grant.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        chan_n  = cur_chan;
        cnt_n   = cnt;
        sr_n    = sr_q;
        law_n   = law_q;
        sp_n    = sp_q;
        spc_n   = spc_q;
        gnt_n   = '0;
        done_n  = '0;
        unique case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_n = S_WAIT;
                    sr_n    = bus.sr_in[int'(win) * SR_W +: SR_W];
                    law_n   = bus.law_in[win];
                    chan_n  = win;
                    gnt_n   = pick;
                    ptr_n   = (win == CH_W'(N_CH - 1)) ? '0 : win + 1'b1;
                    cnt_n   = CNT_W'(CMP_LAT - 1);
                end
            end
            S_WAIT: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    state_n          = S_IDLE;
                    sp_n             = cmp_sp;
                    spc_n            = cur_chan;
                    done_n[cur_chan] = 1'b1;
                end
            end
        endcase
    end

    assign busy        = (state == S_WAIT);
    assign cmp_sr      = sr_q;
    assign cmp_law     = law_q;
    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.sp_out  = sp_q;
    assign bus.sp_chan = spc_q;
endmodule
